// File: rtl/serial_transmitter_pkg.sv
// Shared definitions for the serial transmitter/receiver pair: state encoding,
// line levels and default framing parameters.
package serial_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } ser_state_e;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/serial_transmitter_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and flags the last
// cycle of each bit. Held at zero when idle so every frame starts aligned.
module serial_transmitter_bit_timer
  import serial_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_bit_done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_cnt <= '0;
    else if (!i_run || r_cnt == LAST) r_cnt <= '0;
    else                               r_cnt <= r_cnt + CW'(1);
  end

  assign o_bit_done = i_run && (r_cnt == LAST);

endmodule

// File: rtl/serial_transmitter.sv
// Async serial transmitter: one-byte holding buffer feeding a start/8N/stop
// shifter, with back-to-back frames when the next byte is ready at stop.
module serial_transmitter
  import serial_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  input  logic                 transmit_enable,
  output logic                 data_out,
  output logic                 character_sent,
  output logic                 buffer_full,
  output logic                 busy
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  ser_state_e           r_state;
  logic [DATA_BITS-1:0] r_buf;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_buf_full;
  logic [IW-1:0]        r_bit_idx;
  logic                 r_data_out;
  logic                 r_char_sent;

  logic w_bit_done;
  logic w_take;
  logic w_accept;

  serial_transmitter_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_run      (r_state != ST_IDLE),
    .o_bit_done (w_bit_done)
  );

  // Enable is only looked at where a frame may begin: idle, or the final stop cycle.
  assign w_take   = r_buf_full && transmit_enable &&
                    ((r_state == ST_IDLE) || (r_state == ST_STOP && w_bit_done));
  // A transfer frees the slot in the same cycle, so a coincident load still lands.
  assign w_accept = load && (!r_buf_full || w_take);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_accept)    r_buf <= data_in;
      if (w_accept)    r_buf_full <= 1'b1;
      else if (w_take) r_buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_data_out  <= IDLE_LEVEL;
      r_char_sent <= 1'b0;
    end else begin
      r_char_sent <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_data_out <= IDLE_LEVEL;
          if (w_take) begin
            r_shift    <= r_buf;
            r_state    <= ST_START;
            r_data_out <= START_LEVEL;
          end
        end
        ST_START: if (w_bit_done) begin
          r_state    <= ST_DATA;
          r_bit_idx  <= '0;
          r_data_out <= r_shift[0];
        end
        ST_DATA: if (w_bit_done) begin
          if (r_bit_idx == IW'(DATA_BITS - 1)) begin
            r_state    <= ST_STOP;
            r_data_out <= STOP_LEVEL;
          end else begin
            r_shift    <= r_shift >> 1;
            r_bit_idx  <= r_bit_idx + IW'(1);
            r_data_out <= r_shift[1];
          end
        end
        ST_STOP: if (w_bit_done) begin
          r_char_sent <= 1'b1;
          if (w_take) begin
            r_shift    <= r_buf;
            r_state    <= ST_START;
            r_data_out <= START_LEVEL;
          end else begin
            r_state    <= ST_IDLE;
            r_data_out <= IDLE_LEVEL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign character_sent = r_char_sent;
  assign buffer_full    = r_buf_full;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_transmitter.sv
// Self-checking bench for serial_transmitter: line waveforms are compared against
// a frame model built directly from the start/LSB-first/stop framing rule.
module tb_serial_transmitter;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       load = 1'b0;
  logic       transmit_enable = 1'b0;
  logic       data_out, character_sent, buffer_full, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .load            (load),
    .transmit_enable (transmit_enable),
    .data_out        (data_out),
    .character_sent  (character_sent),
    .buffer_full     (buffer_full),
    .busy            (busy)
  );

  // Expected line level for every cycle of one frame carrying b.
  function automatic logic [FRAME-1:0] model_wave(input logic [7:0] b);
    logic [9:0]       fr;
    logic [FRAME-1:0] w;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) w[i] = fr[i / CPB];
    return w;
  endfunction

  task automatic do_load(input logic [7:0] b);
    data_in = b;
    load    = 1'b1;
    @(posedge clk); #1;
    load    = 1'b0;
  endtask

  // Records one frame at negedges. started=1 means the current negedge is frame cycle 0.
  task automatic capture(input bit started, output logic [FRAME-1:0] wave, output int cs_in,
                         output logic cs_end, output logic lvl_end, output logic busy_end,
                         output bit found);
    found = started; cs_in = 0; wave = '1; cs_end = 1'b0; lvl_end = 1'b1; busy_end = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (data_out === 1'b0) found = 1'b1;
    end
    if (found) begin
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        wave[i] = data_out;
        if (i > 0 && character_sent === 1'b1) cs_in++;
      end
      @(negedge clk);
      cs_end = character_sent; lvl_end = data_out; busy_end = busy;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    #13;
    n_checks++;
    if ({data_out, busy, buffer_full, character_sent} !== 4'b1000)
      $display("FAIL reset_state got=%b exp=1000", {data_out, busy, buffer_full, character_sent});
    else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_out !== 1'b1 || busy !== 1'b0 || character_sent !== 1'b0 || buffer_full !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL idle_quiet bad_cycles=%0d exp=0", bad);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [FRAME-1:0] w;
    int cs_in; logic cs_end, lvl_end, busy_end; bit found;
    logic [7:0] b;
    transmit_enable = 1'b1;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom);
      do_load(b);
      capture(1'b0, w, cs_in, cs_end, lvl_end, busy_end, found);
      n_checks++;
      if (!found) $display("FAIL single_start_timeout byte=%h", b);
      else n_pass++;
      n_checks++;
      if (w !== model_wave(b)) $display("FAIL single_wave byte=%h got=%h exp=%h", b, w, model_wave(b));
      else n_pass++;
      n_checks++;
      if ({cs_in, cs_end, lvl_end, busy_end} !== {32'd0, 1'b1, 1'b1, 1'b0})
        $display("FAIL single_done cs_in=%0d cs_end=%b lvl=%b busy=%b exp=0,1,1,0", cs_in, cs_end, lvl_end, busy_end);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (character_sent !== 1'b0) $display("FAIL single_pulse_width got=%b exp=0", character_sent);
      else n_pass++;
    end
  endtask

  task automatic test_gated_start();
    logic [FRAME-1:0] w;
    int cs_in, bad; logic cs_end, lvl_end, busy_end; bit found;
    transmit_enable = 1'b0;
    do_load(8'h3C);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_out !== 1'b1 || buffer_full !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL gated_hold bad_cycles=%0d exp=0", bad);
    else n_pass++;
    transmit_enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({data_out, busy, buffer_full} !== 3'b010)
      $display("FAIL gated_start_edge got=%b exp=010", {data_out, busy, buffer_full});
    else n_pass++;
    capture(1'b1, w, cs_in, cs_end, lvl_end, busy_end, found);
    n_checks++;
    if (w !== model_wave(8'h3C) || cs_end !== 1'b1) $display("FAIL gated_wave got=%h exp=%h cs=%b", w, model_wave(8'h3C), cs_end);
    else n_pass++;
  endtask

  task automatic test_back_to_back(input logic [7:0] b1, input logic [7:0] b2, input int when);
    logic [FRAME-1:0] w1, w2;
    int cs1, cs2; logic ce1, ce2, le1, le2, be1, be2; bit f1, f2;
    transmit_enable = 1'b1;
    do_load(b1);
    fork
      capture(1'b0, w1, cs1, ce1, le1, be1, f1);
      begin repeat (when) @(posedge clk); #1; do_load(b2); end
    join
    n_checks++;
    if (!f1 || w1 !== model_wave(b1)) $display("FAIL b2b_first_wave found=%b got=%h exp=%h", f1, w1, model_wave(b1));
    else n_pass++;
    n_checks++;
    if ({ce1, le1, be1} !== 3'b101) $display("FAIL b2b_no_gap cs/line/busy got=%b exp=101", {ce1, le1, be1});
    else n_pass++;
    capture(1'b1, w2, cs2, ce2, le2, be2, f2);
    n_checks++;
    if (w2 !== model_wave(b2)) $display("FAIL b2b_second_wave got=%h exp=%h", w2, model_wave(b2));
    else n_pass++;
    n_checks++;
    if ({cs2, ce2, le2} !== {32'd0, 1'b1, 1'b1}) $display("FAIL b2b_second_pulse cs_in=%0d cs_end=%b line=%b", cs2, ce2, le2);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [FRAME-1:0] w1, w2;
    int cs1, cs2, bad; logic ce1, ce2, le1, le2, be1, be2; bit f1, f2;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    if (b2 == 8'h77) b2 = 8'h78;
    transmit_enable = 1'b1;
    do_load(b1);
    fork
      capture(1'b0, w1, cs1, ce1, le1, be1, f1);
      begin
        repeat (30) @(posedge clk); #1;
        do_load(b2);
        n_checks++;
        if (buffer_full !== 1'b1 || busy !== 1'b1) $display("FAIL ovf_full got=%b%b exp=11", buffer_full, busy);
        else n_pass++;
        do_load(8'h77);
      end
    join
    n_checks++;
    if (w1 !== model_wave(b1) || le1 !== 1'b0) $display("FAIL ovf_first got=%h exp=%h line=%b", w1, model_wave(b1), le1);
    else n_pass++;
    capture(1'b1, w2, cs2, ce2, le2, be2, f2);
    n_checks++;
    if (w2 !== model_wave(b2)) $display("FAIL ovf_kept_byte got=%h exp=%h", w2, model_wave(b2));
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_out !== 1'b1 || busy !== 1'b0 || buffer_full !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ovf_no_third_frame bad_cycles=%0d exp=0", bad);
    else n_pass++;
  endtask

  task automatic test_take_load();
    logic [FRAME-1:0] w1, w2;
    int cs1, cs2; logic ce1, ce2, le1, le2, be1, be2; bit f1, f2;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    transmit_enable = 1'b0;
    do_load(b1);
    @(negedge clk);
    transmit_enable = 1'b1;
    data_in = b2; load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    n_checks++;
    if ({buffer_full, busy} !== 2'b11) $display("FAIL take_load_flags got=%b exp=11", {buffer_full, busy});
    else n_pass++;
    capture(1'b0, w1, cs1, ce1, le1, be1, f1);
    n_checks++;
    if (w1 !== model_wave(b1) || le1 !== 1'b0) $display("FAIL take_load_first got=%h exp=%h line=%b", w1, model_wave(b1), le1);
    else n_pass++;
    capture(1'b1, w2, cs2, ce2, le2, be2, f2);
    n_checks++;
    if (w2 !== model_wave(b2)) $display("FAIL take_load_second got=%h exp=%h", w2, model_wave(b2));
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [FRAME-1:0] w;
    int cs_in, bad; logic cs_end, lvl_end, busy_end; bit found;
    logic [7:0] b1, b3;
    b1 = 8'($urandom); b3 = 8'($urandom);
    transmit_enable = 1'b1;
    do_load(b1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (data_out === 1'b0) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL rmid_start_timeout");
    else n_pass++;
    data_in = 8'($urandom); load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    repeat (87) @(negedge clk);
    n_checks++;
    if (data_out !== b1[4] || buffer_full !== 1'b1) $display("FAIL rmid_bit4 got=%b%b exp=%b1", data_out, buffer_full, b1[4]);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({data_out, busy, buffer_full, character_sent} !== 4'b1000)
      $display("FAIL rmid_async got=%b exp=1000", {data_out, busy, buffer_full, character_sent});
    else n_pass++;
    repeat (3) @(posedge clk); #1; rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_out !== 1'b1 || character_sent !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL rmid_quiet bad_cycles=%0d exp=0", bad);
    else n_pass++;
    do_load(b3);
    capture(1'b0, w, cs_in, cs_end, lvl_end, busy_end, found);
    n_checks++;
    if (!found || w !== model_wave(b3) || cs_end !== 1'b1)
      $display("FAIL rmid_clean_frame got=%h exp=%h cs=%b", w, model_wave(b3), cs_end);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_gated_start();
    test_back_to_back(8'h01, 8'hFF, 40);
    test_back_to_back(8'($urandom), 8'($urandom), 150);
    test_overflow();
    test_take_load();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- Upstream neighbour of the serial receiver: takes a byte from the microprocessor's parallel output port and drives it as an asynchronous serial frame onto the GPIO line that the receiver samples.
- Frame: idle-high line, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Holds one byte in a buffer so software can load the next character while the current one shifts out.
- Reports per-frame completion to the processor via character_sent.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit. 16 matches the receiver's minor/major clock ratio when this block runs on the minor clock.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  block clock (bit timing derived from it)
- rst  input  1  asynchronous, active-low reset
- data_in  input  8  parallel byte from the processor data bus
- load  input  1  one-cycle strobe: capture data_in into the holding buffer
- transmit_enable  input  1  level: permits a new frame to start
- data_out  output  1  serial line to GPIO; idle high
- character_sent  output  1  one-cycle pulse when a frame's stop bit completes
- buffer_full  output  1  holding buffer occupied
- busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, data_out=1, character_sent=0, buffer_full=0, busy=0, all counters 0. A frame in progress is abandoned immediately and the line returns high without glitching low. The holding buffer is emptied.
- Holding buffer:
  - load=1 with buffer_full=0: capture data_in and set buffer_full next edge.
  - load=1 with buffer_full=1: ignore the load; the buffer is unchanged. No overwrite is allowed.
- States:
  - IDLE: data_out=1. If buffer_full && transmit_enable, move the buffer into the shift register, clear buffer_full, go to START.
  - START: data_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: data_out=shift[0] for CLKS_PER_BIT cycles. Then shift right and bit_idx++. After bit_idx reaches DATA_BITS-1, go to STOP.
  - STOP: data_out=1 for CLKS_PER_BIT cycles. On the last cycle, pulse character_sent for exactly 1 cycle. If buffer_full && transmit_enable, go straight to START with the new byte (back-to-back, no idle gap). Otherwise go to IDLE.
- Timing:
  - data_out is registered.
  - The start bit begins 1 cycle after the IDLE cycle that sees buffer_full && transmit_enable.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles.
- Tick counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width is $clog2(CLKS_PER_BIT).
- transmit_enable drop mid-frame: the current frame completes. The gate is only sampled at frame start (IDLE, or the last STOP cycle).
- Simultaneous events:
  - load on the same cycle the buffer is transferred into the shift register: the load is accepted. The transfer frees the slot, so buffer_full stays 1 with the new byte.
  - load on the last STOP cycle with the buffer empty: the byte is captured, but the next frame starts from IDLE one cycle later.
- busy=1 from the first start-bit cycle through the last stop-bit cycle.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, START, DATA, STOP)
  - frame constants: START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1
  - default CLKS_PER_BIT
- The receiver uses the same package.
- One natural sub-module: bit_timer (tick counter with a bit_done output), shared with the receiver's bit-period logic.

Test Plan:
- Reset then idle: rst released, no load for 100 cycles -> data_out=1 throughout; busy=0; character_sent never pulses.
- Single byte: load 8'hA5 with transmit_enable=1 -> data_out sequence, each bit held 16 cycles: 0,1,0,1,0,0,1,0,1,1. character_sent pulses once at cycle 160 of the frame.
- Gated start: load 8'h3C with transmit_enable=0 for 50 cycles -> buffer_full=1, data_out=1. Raise enable -> start bit begins next cycle and frame carries 3C.
- Back-to-back: load 8'h01, then load 8'hFF mid-frame -> second start bit immediately follows the first stop bit with no idle cycle. Two character_sent pulses 160 cycles apart.
- Overflow: while busy with buffer_full=1, load 8'h77 -> ignored; the next frame carries the earlier buffered byte.
- Reset mid-frame: assert rst during DATA bit 4 -> data_out=1 asynchronously, busy=0, buffer_full=0, no character_sent pulse. A new load after release sends a clean frame.
